// File: rtl/lsu_pkg.sv
// Shared encodings for the rvseed load/store unit: access sizes, FSM states
// and the word-alignment mask.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Byte-offset bits of an address; cleared to form the word address.
    localparam logic [1:0] WORD_OFF_MASK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_STORE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    // Encoding 2'b11 is treated as a word access, so only bit 1 matters.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// Load lane extraction: selects the byte/half lane of a memory word and
// sign- or zero-extends it to 32 bits.
module lsu_lane_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        w_half = i_word[{i_offset[1], 4'b0000} +: 16];
        if (is_word(i_size)) begin
            o_data = i_word;
        end else if (i_size == SIZE_H) begin
            o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
        end else begin
            o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rvseed load/store unit: byte/half/word accesses to a word-organised memory,
// sub-word stores as read-modify-write. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_misalign,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e            r_state;
    lsu_state_e            w_next_state;

    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_merge;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_accept;
    logic                  w_misalign;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_word_addr = r_addr & ~ADDR_WIDTH'(WORD_OFF_MASK);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_misalign   = ((req_size == SIZE_H) && req_addr[0])
                        || (is_word(req_size) && (req_addr[1:0] != 2'b00));
    assign rsp_misalign = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_misalign <= w_misalign;
        end
    end
`else
    assign w_misalign   = 1'b0;
    assign rsp_misalign = 1'b0;
`endif

    // NOTE: request fields are only consumed after a state that latched them,
    // so they carry no reset; only state and response/merge registers do.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
            r_merge <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_rdata <= '0;
            end else if (r_state == ST_LOAD) begin
                r_rdata <= w_load_data;
            end
            if (r_state == ST_MERGE) begin
                r_merge <= w_merged;
            end
        end
    end

    lsu_lane_ext u_lane_ext (
        .i_word     (mem_rdata),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    always_comb begin
        w_merged = mem_rdata;
        if (r_size == SIZE_B) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred;
    // enables are gated with rst_n so nothing reaches memory during reset.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_raddr    = '0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    if (w_misalign) begin
                        w_next_state = ST_RESP;
                    end else if (!req_we) begin
                        w_next_state = ST_LOAD;
                    end else if (is_word(req_size)) begin
                        w_next_state = ST_STORE;
                    end else begin
                        w_next_state = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                mem_ren      = rst_n;
                mem_raddr    = w_word_addr;
                w_next_state = ST_RESP;
            end
            ST_MERGE: begin
                mem_ren      = rst_n;
                mem_raddr    = w_word_addr;
                w_next_state = ST_STORE;
            end
            ST_STORE: begin
                mem_wen      = rst_n;
                mem_waddr    = w_word_addr;
                mem_wdata    = is_word(r_size) ? r_wdata : r_merge;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid    = rst_n;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-organised memory model;
// covers both builds of LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wen_cnt  = 0;
    int rsp_cnt  = 0;
    int wen_base;
    int rsp_base;

    load_store_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .mem_wen      (mem_wen),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_ren      (mem_ren),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_raddr[7:2]];

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_wen) begin
            mem[mem_waddr[7:2]] <= mem_wdata;
        end
        if (mem_wen) wen_cnt <= wen_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] exp);
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 1);
        send(1'b0, sz, uns, a, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_ren"}, mem_ren, 1);
        check({tag, "_raddr"}, mem_raddr, a & 32'hFFFF_FFFC);
        check({tag, "_wen"}, mem_wen, 0);
        check({tag, "_busy"}, req_ready, 0);
        @(negedge clk);
        check({tag, "_rsp"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, exp);
        check({tag, "_mis"}, rsp_misalign, 0);
    endtask

    task automatic do_sub_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] wd, input logic [31:0] exp_word);
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 1);
        send(1'b1, sz, 1'b0, a, wd);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_ren"}, mem_ren, 1);
        check({tag, "_raddr"}, mem_raddr, a & 32'hFFFF_FFFC);
        check({tag, "_wen0"}, mem_wen, 0);
        @(negedge clk);
        check({tag, "_wen"}, mem_wen, 1);
        check({tag, "_waddr"}, mem_waddr, a & 32'hFFFF_FFFC);
        check({tag, "_wdata"}, mem_wdata, exp_word);
        check({tag, "_ren1"}, mem_ren, 0);
        @(negedge clk);
        check({tag, "_rsp"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        bd_we        = 1'b0;
        bd_idx       = 6'd0;
        bd_data      = 32'h0;

        // Reset: enables low, memory preloaded through the backdoor meanwhile.
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_rsp", rsp_valid, 0);
        preload(6'd4, 32'h8899_AABB);
        preload(6'd8, 32'h1122_3344);
        preload(6'd1, 32'hCAFE_F00D);
        check("rst_ren", mem_ren, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_mis", rsp_misalign, 0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_ready", req_ready, 1);

        // Loads from word 0x10 = 0x8899AABB.
        do_load("ld_b13s", 32'h13, 2'b00, 1'b0, 32'hFFFF_FF88);
        @(negedge clk);
        check("ld_rsp_drop", rsp_valid, 0);
        check("ld_idle_ready", req_ready, 1);
        do_load("ld_b13u", 32'h13, 2'b00, 1'b1, 32'h0000_0088);
        do_load("ld_h12s", 32'h12, 2'b01, 1'b0, 32'hFFFF_8899);
        do_load("ld_h10u", 32'h10, 2'b01, 1'b1, 32'h0000_AABB);
        do_load("ld_b11s", 32'h11, 2'b00, 1'b0, 32'hFFFF_FFAA);
        do_load("ld_b10s", 32'h10, 2'b00, 1'b0, 32'hFFFF_FFBB);
        do_load("ld_w10", 32'h10, 2'b10, 1'b0, 32'h8899_AABB);
        do_load("ld_s3_10", 32'h10, 2'b11, 1'b1, 32'h8899_AABB);

        // Half store into 0x11223344, then reload the word.
        do_sub_store("st_h22", 32'h22, 2'b01, 32'h1234_BEEF, 32'hBEEF_3344);
        check("st_h22_mem", mem[8], 32'hBEEF_3344);
        do_load("ld_after_st", 32'h20, 2'b10, 1'b0, 32'hBEEF_3344);

        // Byte store at lane 1.
        do_sub_store("st_b21", 32'h21, 2'b00, 32'hFFFF_FF5A, 32'hBEEF_5A44);
        check("st_b21_mem", mem[8], 32'hBEEF_5A44);

        // Word store: single write cycle, no read.
        @(negedge clk);
        check("st_w_ready", req_ready, 1);
        send(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
        @(negedge clk);
        req_valid = 1'b0;
        check("st_w_wen", mem_wen, 1);
        check("st_w_waddr", mem_waddr, 32'h40);
        check("st_w_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_w_ren", mem_ren, 0);
        @(negedge clk);
        check("st_w_rsp", rsp_valid, 1);
        check("st_w_wen_off", mem_wen, 0);
        check("st_w_mem", mem[16], 32'hDEAD_BEEF);

        // Half load at odd address 0x41.
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        check("mis_ready", req_ready, 1);
        send(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("mis_rsp", rsp_valid, 1);
        check("mis_flag", rsp_misalign, 1);
        check("mis_rdata", rsp_rdata, 0);
        check("mis_ren", mem_ren, 0);
        check("mis_wen", mem_wen, 0);
`else
        do_load("mis_ld", 32'h41, 2'b01, 1'b0, 32'hFFFF_BEEF);
`endif

        // Byte store at 0x05 aborted by reset during MERGE.
        @(negedge clk);
        check("abort_ready", req_ready, 1);
        send(1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_0077);
        wen_base = wen_cnt;
        rsp_base = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_merge_ren", mem_ren, 1);
        check("abort_merge_raddr", mem_raddr, 32'h04);
        rst_n = 1'b0;
        #1;
        check("abort_ren_gated", mem_ren, 0);
        check("abort_ready_low", req_ready, 0);
        @(negedge clk);
        check("abort_wen0", mem_wen, 0);
        check("abort_rsp0", rsp_valid, 0);
        @(negedge clk);
        check("abort_wen1", mem_wen, 0);
        rst_n = 1'b1;
        #1;
        check("abort_ready", req_ready, 1);
        @(negedge clk);
        check("abort_wen_cnt", wen_cnt, wen_base);
        check("abort_rsp_cnt", rsp_cnt, rsp_base);
        check("abort_mem", mem[1], 32'hCAFE_F00D);
        check("abort_idle", req_ready, 1);
        check("abort_rdata", rsp_rdata, 0);

        // Back-to-back: second request held until the cycle after the first RESP.
        @(negedge clk);
        rsp_base = rsp_cnt;
        check("b2b_ready0", req_ready, 1);
        send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("b2b_ld1_ren", mem_ren, 1);
        check("b2b_ld1_busy", req_ready, 0);
        send(1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
        #1;
        check("b2b_ld1_raddr", mem_raddr, 32'h20);
        @(negedge clk);
        check("b2b_rsp1", rsp_valid, 1);
        check("b2b_rdata1", rsp_rdata, 32'hBEEF_5A44);
        check("b2b_resp_busy", req_ready, 0);
        @(negedge clk);
        check("b2b_idle_ready", req_ready, 1);
        check("b2b_idle_rsp", rsp_valid, 0);
        check("b2b_idle_ren", mem_ren, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_ld2_ren", mem_ren, 1);
        check("b2b_ld2_raddr", mem_raddr, 32'h40);
        @(negedge clk);
        check("b2b_rsp2", rsp_valid, 1);
        check("b2b_rdata2", rsp_rdata, 32'h0000_00DE);
        @(negedge clk);
        check("b2b_rsp_cnt", rsp_cnt, rsp_base + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
